bin_to_bcd_converter: RTL and testbench

//  Sequential double-dabble converter: turns a binary result word from the CPU into four BCD digits
//  (units/tens/hundreds/thousands) for the seven-segment display driver, which consumes them directly.

---
 rtl/display_pkg.sv | 21 ++
 rtl/bcd_digit_adjust.sv | 14 +
 rtl/bin_to_bcd_converter.sv | 142 ++++++++++++++
 tb/tb_bin_to_bcd_converter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants, FSM state type and BCD helper for the display path.
package display_pkg;

  localparam int unsigned BCD_W            = 4;
  localparam logic [3:0]  BLANK_DIGIT      = 4'hF;
  localparam int unsigned MAX_DISP_DEFAULT = 9999;
  localparam int unsigned SCRATCH_DIGITS   = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Decimal value of four packed BCD digits (digit 3 in the top nibble).
  function automatic logic [31:0] bcd4_value(input logic [15:0] d);
    return 32'(d[15:12]) * 32'd1000 + 32'(d[11:8]) * 32'd100
         + 32'(d[7:4]) * 32'd10 + 32'(d[3:0]);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter (one bit per clock) with start/busy/done.
// Build option SIGNED_INPUT_EN: treat bin as two's complement and report the sign on neg.
module bin_to_bcd_converter
  import display_pkg::*;
#(
  parameter int unsigned IN_W     = 14,
  parameter int unsigned MAX_DISP = MAX_DISP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [3:0]      units,
  output logic [3:0]      tens,
  output logic [3:0]      hundreds,
  output logic [3:0]      thousands,
  output logic            ovf,
  output logic            neg
);

  localparam int unsigned CNT_W = $clog2(IN_W);
  localparam int unsigned SCR_W = SCRATCH_DIGITS * BCD_W;
  localparam int unsigned DIG_W = 4 * BCD_W;

  state_e             state_q, state_d;
  logic [IN_W-1:0]    shreg_q, shreg_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [SCR_W-1:0]   scratch_adj;
  logic [SCR_W-1:0]   scratch_shift;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIG_W-1:0]   digits_q, digits_d;
  logic               ovf_q, ovf_d;
  logic [IN_W-1:0]    bin_mag;
  logic               accept;
  logic               finish;
  logic               res_ovf;

  for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (scratch_q[g*BCD_W +: BCD_W]),
      .dout (scratch_adj[g*BCD_W +: BCD_W])
    );
  end

  assign scratch_shift = {scratch_adj[SCR_W-2:0], shreg_q[IN_W-1]};
  assign accept        = (state_q == S_IDLE) && start;
  assign finish        = (state_q == S_SHIFT) && (cnt_q == '0);
  assign res_ovf       = (scratch_shift[SCR_W-1 -: BCD_W] != '0)
                      || (bcd4_value(scratch_shift[DIG_W-1:0]) > MAX_DISP);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d   = bin_mag;
          scratch_d = '0;
          cnt_d     = CNT_W'(IN_W - 1);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scratch_d = scratch_shift;
        shreg_d   = {shreg_q[IN_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          // Result registers load on the edge into DONE so they are valid while done is high.
          state_d  = S_DONE;
          ovf_d    = res_ovf;
          digits_d = res_ovf ? {4{BLANK_DIGIT}} : scratch_shift[DIG_W-1:0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef SIGNED_INPUT_EN
  logic sign_q, sign_d;
  logic neg_q, neg_d;

  // Most negative input negates to itself, which reads as the unsigned magnitude 2^(IN_W-1).
  assign bin_mag = bin[IN_W-1] ? (~bin + IN_W'(1)) : bin;

  always_comb begin
    sign_d = sign_q;
    neg_d  = neg_q;
    if (accept) sign_d = bin[IN_W-1];
    if (finish) neg_d  = sign_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      sign_q <= sign_d;
      neg_q  <= neg_d;
    end
  end

  assign neg = neg_q;
`else
  assign bin_mag = bin;
  assign neg     = 1'b0;
`endif

  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign units     = digits_q[3:0];
  assign tens      = digits_q[7:4];
  assign hundreds  = digits_q[11:8];
  assign thousands = digits_q[15:12];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter: vector table plus handshake/reset sequences.
module tb_bin_to_bcd_converter;

  localparam int IN_W = 14;

  logic            clk, rst, start;
  logic [IN_W-1:0] bin;
  logic            busy, done, ovf, neg;
  logic [3:0]      units, tens, hundreds, thousands;

  typedef struct {
    logic [IN_W-1:0] bin;
    logic [3:0]      u, t, h, k;
    logic            ovf;
    logic            neg;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  vec_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;

  bin_to_bcd_converter #(.IN_W(IN_W), .MAX_DISP(9999)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .units     (units),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .ovf       (ovf),
    .neg       (neg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int b, input int u, input int t, input int h,
                              input int k, input bit o, input bit n);
    vec_t v;
    v.bin = IN_W'(b);
    v.u = 4'(u); v.t = 4'(t); v.h = 4'(h); v.k = 4'(k);
    v.ovf = o; v.neg = n;
    return v;
  endfunction

  // Independent reference: decimal arithmetic on the magnitude.
  function automatic vec_t model(input logic [IN_W-1:0] b);
    vec_t v;
    int   mag;
    v.bin = b;
    v.neg = 1'b0;
    mag   = int'(b);
`ifdef SIGNED_INPUT_EN
    if (b[IN_W-1]) begin
      v.neg = 1'b1;
      mag   = (1 << IN_W) - int'(b);
    end
`endif
    if (mag > 9999) begin
      v.ovf = 1'b1;
      v.u = 4'hF; v.t = 4'hF; v.h = 4'hF; v.k = 4'hF;
    end else begin
      v.ovf = 1'b0;
      v.u = 4'(mag % 10);
      v.t = 4'((mag / 10) % 10);
      v.h = 4'((mag / 100) % 10);
      v.k = 4'((mag / 1000) % 10);
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) chk("busy_done_overlap", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("units[%0d]", mon_e.bin), int'(units), int'(mon_e.u));
          chk($sformatf("tens[%0d]", mon_e.bin), int'(tens), int'(mon_e.t));
          chk($sformatf("hundreds[%0d]", mon_e.bin), int'(hundreds), int'(mon_e.h));
          chk($sformatf("thousands[%0d]", mon_e.bin), int'(thousands), int'(mon_e.k));
          chk($sformatf("ovf[%0d]", mon_e.bin), int'(ovf), int'(mon_e.ovf));
          chk($sformatf("neg[%0d]", mon_e.bin), int'(neg), int'(mon_e.neg));
        end
      end
    end
  end

  // Waits for idle, pulses start, and checks latency and busy length.
  task automatic convert(input vec_t e);
    int cyc, bcnt, guard;
    guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    bin   = e.bin;
    start = 1'b1;
    sb.push_back(e);
    cyc  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) bcnt++;
    end while (!done && cyc < 40);
    chk("latency", cyc, 15);
    chk("busy_cycles", bcnt, 14);
  endtask

  initial begin
    int cyc, bcnt, dcnt;
    rst   = 1'b0;
    start = 1'b0;
    bin   = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_digits", int'({thousands, hundreds, tens, units}), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_neg", int'(neg), 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef SIGNED_INPUT_EN
    tbl.push_back(mk(14'h3FFF, 1, 0, 0, 0, 1'b0, 1'b1));
    tbl.push_back(mk(14'h2000, 2, 9, 1, 8, 1'b0, 1'b1));
    tbl.push_back(mk(1234,     4, 3, 2, 1, 1'b0, 1'b0));
    tbl.push_back(mk(14'h3B2E, 4, 3, 2, 1, 1'b0, 1'b1));
    tbl.push_back(mk(8191,     1, 9, 1, 8, 1'b0, 1'b0));
    tbl.push_back(mk(0,        0, 0, 0, 0, 1'b0, 1'b0));
    tbl.push_back(mk(42,       2, 4, 0, 0, 1'b0, 1'b0));
`else
    tbl.push_back(mk(1234,  4, 3, 2, 1, 1'b0, 1'b0));
    tbl.push_back(mk(0,     0, 0, 0, 0, 1'b0, 1'b0));
    tbl.push_back(mk(9999,  9, 9, 9, 9, 1'b0, 1'b0));
    tbl.push_back(mk(10000, 15, 15, 15, 15, 1'b1, 1'b0));
    tbl.push_back(mk(42,    2, 4, 0, 0, 1'b0, 1'b0));
    tbl.push_back(mk(16383, 15, 15, 15, 15, 1'b1, 1'b0));
    tbl.push_back(mk(1000,  0, 0, 0, 1, 1'b0, 1'b0));
    tbl.push_back(mk(5,     5, 0, 0, 0, 1'b0, 1'b0));
    tbl.push_back(mk(8888,  8, 8, 8, 8, 1'b0, 1'b0));
`endif
    for (int i = 0; i < 8; i++) tbl.push_back(model(IN_W'($urandom_range(0, 16383))));

    for (int i = 0; i < tbl.size(); i++) convert(tbl[i]);

    // Start during SHIFT (cycle 5) and during DONE must both be dropped.
    @(negedge clk);
    while (busy || done) @(negedge clk);
    bin   = IN_W'(1234);
    start = 1'b1;
    sb.push_back(model(IN_W'(1234)));
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 5) begin
        bin   = IN_W'(777);
        start = 1'b1;
      end
    end while (!done && cyc < 40);
    chk("ignored_start_latency", cyc, 15);
    bin   = IN_W'(555);
    start = 1'b1;
    bcnt  = 0;
    dcnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) dcnt++;
    end
    chk("start_in_done_busy", bcnt, 0);
    chk("start_in_done_done", dcnt, 0);

    // Reset at cycle 7 of a conversion aborts it with no done pulse.
    bin   = IN_W'(5555);
    start = 1'b1;
    cyc   = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (cyc < 7);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_digits", int'({thousands, hundreds, tens, units}), 0);
    chk("abort_ovf", int'(ovf), 0);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    convert(model(IN_W'(42)));

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
